// File: rtl/aes256_decrypt_iter.sv
// Iterative AES-256 inverse cipher, one round per clock.
// Ports: clk, rst_n (sync, active-high), ready/data_in in, key[14:0] round keys, data_out/valid out.
module aes256_decrypt_iter #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key [14:0],
    output logic [127:0] data_out,
    output logic         valid
);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    localparam logic [3:0] FIRST_RND = 4'(NR - 1);

    state_e       fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;
    logic [127:0] dout_q, dout_d;
    logic         valid_q, valid_d;
    logic [127:0] rnd_x;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // inverse affine map first, then field inverse
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        for (int i = 0; i < 8; i++) begin
            a[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
        end
        return gf_inv(a ^ 8'h05);
    endfunction

    // byte 4c+r sits at row r, column c; row r rotates right by r
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    // multiply by a constant built from 1, 2, 4, 8
    function automatic logic [7:0] mulx(input logic [7:0] a,
                                        input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? a : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [3:0] imc_coef(input int k);
        logic [3:0] v;
        unique case (k)
            0:       v = 4'he;
            1:       v = 4'hb;
            2:       v = 4'hd;
            default: v = 4'h9;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ mulx(s[127 - 8 * (4 * c + j) -: 8],
                                     imc_coef((j - r + 4) % 4));
                end
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        rnd_x   = inv_shift_sub(st_q) ^ key[rnd_q];
        unique case (fsm_q)
            IDLE: begin
                if (ready) begin
                    st_d  = data_in ^ key[NR];
                    rnd_d = FIRST_RND;
                    fsm_d = RUN;
                end
            end
            RUN: begin
                if (rnd_q == 4'd0) begin
                    dout_d  = rnd_x;
                    valid_d = 1'b1;
                    fsm_d   = IDLE;
                end else begin
                    st_d  = inv_mix(rnd_x);
                    rnd_d = rnd_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            st_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    assign data_out = dout_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_aes256_decrypt_iter.sv
// Directed bench for aes256_decrypt_iter.
// Round keys and round-trip ciphertext come from a forward AES-256 model.
module tb_aes256_decrypt_iter;

    logic         clk;
    logic         rst_n;
    logic         ready;
    logic [127:0] data_in;
    logic [127:0] key_arr [14:0];
    logic [127:0] data_out;
    logic         valid;

    int n_chk;
    int n_pass;

    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] C3_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] Z_CT = 128'hdc95c078a2408989ad48a21492842087;

    aes256_decrypt_iter #(.NR(14)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ready    (ready),
        .data_in  (data_in),
        .key      (key_arr),
        .data_out (data_out),
        .valid    (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] y;
        inv = 8'h00;
        for (int k = 1; k < 256; k++) begin
            if (gmul(x, 8'(k)) == 8'h01) inv = 8'(k);
        end
        for (int i = 0; i < 8; i++) begin
            y[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                   inv[(i + 6) % 8] ^ inv[(i + 7) % 8];
        end
        return y ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            tmp = w[i - 1];
            if (i % 8 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xt(rc);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i - 8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) begin
            key_arr[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
        end
    endtask

    function automatic logic [7:0] mc_coef(input int k);
        logic [7:0] v;
        case (k)
            0:       v = 8'h02;
            1:       v = 8'h03;
            default: v = 8'h01;
        endcase
        return v;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt);
        logic [127:0] s;
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   acc;
        s = pt ^ key_arr[0];
        for (int rn = 1; rn < 15; rn++) begin
            t = '0;
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    t[127 - 8 * (4 * c + r) -: 8] =
                        sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
                end
            end
            if (rn < 14) begin
                m = '0;
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) begin
                            acc = acc ^ gmul(t[127 - 8 * (4 * c + j) -: 8],
                                             mc_coef((j - r + 4) % 4));
                        end
                        m[127 - 8 * (4 * c + r) -: 8] = acc;
                    end
                end
                t = m;
            end
            s = t ^ key_arr[rn];
        end
        return s;
    endfunction

    // Called 1 time unit after an edge; returns 1 time unit after the
    // edge that raised valid (or after the cycle budget runs out).
    task automatic run_block(input logic [127:0] ct, input logic [127:0] pt,
                             input string tag);
        int lat;
        ready   = 1'b1;
        data_in = ct;
        @(posedge clk);
        #1;
        ready = 1'b0;
        lat   = 0;
        while (!valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_lat"}, 128'(lat), 128'd14);
        check({tag, "_pt"}, data_out, pt);
    endtask

    initial begin
        logic [127:0] ct;
        int pulses;
        int first_e;
        logic [127:0] first_d;
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b1;
        ready   = 1'b0;
        data_in = '0;
        for (int r = 0; r < 15; r++) key_arr[r] = '0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        check("rst_valid", 128'(valid), 128'd0);
        check("rst_dout", data_out, 128'd0);

        expand(C3_KEY);
        @(posedge clk);
        #1;
        run_block(C3_CT, C3_PT, "c3");
        @(posedge clk);
        #1;
        check("c3_pulse_end", 128'(valid), 128'd0);
        check("c3_hold", data_out, C3_PT);

        expand(256'd0);
        run_block(Z_CT, 128'd0, "zero");

        expand(256'd1);
        ct = aes_enc(128'h69);
        @(posedge clk);
        #1;
        run_block(ct, 128'h69, "rtrip");

        // busy drop: second strobe 5 cycles after acceptance
        expand(C3_KEY);
        @(posedge clk);
        #1;
        ready   = 1'b1;
        data_in = C3_CT;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ready   = 1'b1;
        data_in = Z_CT;
        @(posedge clk);
        #1;
        ready   = 1'b0;
        pulses  = 0;
        first_e = 0;
        first_d = '0;
        for (int e = 6; e <= 32; e++) begin
            @(posedge clk);
            #1;
            if (valid) begin
                pulses++;
                if (pulses == 1) begin
                    first_e = e;
                    first_d = data_out;
                end
            end
        end
        check("busy_pulses", 128'(pulses), 128'd1);
        check("busy_edge", 128'(first_e), 128'd14);
        check("busy_pt", first_d, C3_PT);

        run_block(C3_CT, C3_PT, "b2b_a");
        run_block(C3_CT, C3_PT, "b2b_b");

        // reset for one cycle at round 7
        @(posedge clk);
        #1;
        ready   = 1'b1;
        data_in = C3_CT;
        @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        check("midrst_pulses", 128'(pulses), 128'd0);
        check("midrst_dout", data_out, 128'd0);
        run_block(C3_CT, C3_PT, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
